// File: rtl/ifetch_align.sv
// rtl/ifetch_align.sv - instruction fetch front end aligning 16/32-bit instructions from a word memory
module ifetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_is_c
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    // Reset images of the architectural pointers.
    localparam logic [31:0] RESET_HEAD  = {RESET_PC[31:1], 1'b0};
    localparam logic [31:0] RESET_FETCH = {RESET_PC[31:2], 2'b00};

    state_t      r_state;
    state_t      w_state_nxt;

    // Halfword queue; entry 0 is the head.
    logic [15:0] r_hq [3];
    logic [15:0] w_hq_nxt [3];
    logic [1:0]  r_hq_count;
    logic [1:0]  w_hq_count_nxt;

    logic [31:0] r_head_pc;
    logic [31:0] w_head_pc_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_nxt;
    // Address of the outstanding request; held separately from fetch_pc
    // so a redirect can retarget fetch_pc while a stale request is open.
    logic [31:0] r_req_addr;
    logic        r_skip_lo;
    logic        w_skip_lo_nxt;

    logic        w_head_is_c;
    logic        w_inst_valid;
    logic        w_pop;
    logic [1:0]  w_pop_n;
    logic [1:0]  w_count_popped;
    logic        w_accept;
    logic        w_load_req;

    // Head decode and the decoder-facing handshake.
    always_comb begin
        w_head_is_c  = (r_hq[0][1:0] != 2'b11);
        w_inst_valid = !redirect &&
                       ((r_hq_count >= 2'd2) ||
                        ((r_hq_count >= 2'd1) && w_head_is_c));
        w_pop        = w_inst_valid && inst_ready;
        w_pop_n      = 2'd0;
        if (w_pop) begin
            w_pop_n = w_head_is_c ? 2'd1 : 2'd2;
        end
        w_count_popped = r_hq_count - w_pop_n;
        // Only a response to a live request is kept; a redirect in the
        // same cycle makes it stale.
        w_accept = (r_state == S_REQ) && imem_ack && !redirect;
    end

    // Queue update: drop popped entries first, then append the new halfwords.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_hq_nxt[i] = r_hq[i];
        end
        case (w_pop_n)
            2'd1: begin
                w_hq_nxt[0] = r_hq[1];
                w_hq_nxt[1] = r_hq[2];
            end
            2'd2: begin
                w_hq_nxt[0] = r_hq[2];
            end
            default: ;
        endcase
        w_hq_count_nxt = w_count_popped;
        if (redirect) begin
            w_hq_count_nxt = 2'd0;
        end else if (w_accept) begin
            if (r_skip_lo) begin
                for (int i = 0; i < 3; i++) begin
                    if (2'(i) == w_count_popped) begin
                        w_hq_nxt[i] = imem_rdata[31:16];
                    end
                end
                w_hq_count_nxt = w_count_popped + 2'd1;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (2'(i) == w_count_popped) begin
                        w_hq_nxt[i] = imem_rdata[15:0];
                    end
                    if (2'(i) == w_count_popped + 2'd1) begin
                        w_hq_nxt[i] = imem_rdata[31:16];
                    end
                end
                w_hq_count_nxt = w_count_popped + 2'd2;
            end
        end
    end

    // Pointer and skip flag updates; a redirect overrides everything else.
    always_comb begin
        w_head_pc_nxt  = r_head_pc;
        w_fetch_pc_nxt = r_fetch_pc;
        w_skip_lo_nxt  = r_skip_lo;
        if (redirect) begin
            w_head_pc_nxt  = {redirect_pc[31:1], 1'b0};
            w_fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
            w_skip_lo_nxt  = redirect_pc[1];
        end else begin
            if (w_pop) begin
                w_head_pc_nxt = r_head_pc + (w_head_is_c ? 32'd2 : 32'd4);
            end
            if (w_accept) begin
                w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                w_skip_lo_nxt  = 1'b0;
            end
        end
    end

    // Fetch FSM next state; w_load_req marks the start of a new request.
    always_comb begin
        w_state_nxt = r_state;
        w_load_req  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (redirect || (w_count_popped <= 2'd1)) begin
                    w_state_nxt = S_REQ;
                    w_load_req  = 1'b1;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    if (imem_ack) begin
                        w_state_nxt = S_REQ;
                        w_load_req  = 1'b1;
                    end else begin
                        w_state_nxt = S_DISCARD;
                    end
                end else if (imem_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (imem_ack) begin
                    w_state_nxt = S_REQ;
                    w_load_req  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset wins over redirect and any in-flight ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hq_count <= 2'd0;
            r_head_pc  <= RESET_HEAD;
            r_fetch_pc <= RESET_FETCH;
            r_req_addr <= RESET_FETCH;
            r_skip_lo  <= RESET_PC[1];
            for (int i = 0; i < 3; i++) begin
                r_hq[i] <= 16'h0000;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_hq_count <= w_hq_count_nxt;
            r_head_pc  <= w_head_pc_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_skip_lo  <= w_skip_lo_nxt;
            if (w_load_req) begin
                r_req_addr <= w_fetch_pc_nxt;
            end
            for (int i = 0; i < 3; i++) begin
                r_hq[i] <= w_hq_nxt[i];
            end
        end
    end

    // Output drive.
    always_comb begin
        imem_req   = (r_state != S_IDLE);
        imem_addr  = {r_req_addr[31:2], 2'b00};
        inst_valid = w_inst_valid;
        inst_is_c  = w_head_is_c;
        inst_pc    = r_head_pc;
        inst       = w_head_is_c ? {16'h0000, r_hq[0]} : {r_hq[1], r_hq[0]};
    end

endmodule

// File: tb/tb_ifetch_align.sv
// tb/tb_ifetch_align.sv - directed self-checking bench for ifetch_align
module tb_ifetch_align;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_is_c;

    int checks;
    int failures;

    ifetch_align #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_is_c  (inst_is_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_inst(input string tag, input logic [31:0] e_inst,
                            input logic [31:0] e_pc, input logic e_c);
        check({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        check({tag, "_inst"}, inst, e_inst);
        check({tag, "_pc"}, inst_pc, e_pc);
        check({tag, "_is_c"}, {31'd0, inst_is_c}, {31'd0, e_c});
    endtask

    task automatic wait_req(input string tag, input logic [31:0] e_addr);
        int n;
        n = 0;
        while (!imem_req && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        check({tag, "_addr"}, imem_addr, e_addr);
    endtask

    task automatic cyc;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int acks;
        int bad;
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_no_req", {31'd0, imem_req}, 32'd0);
        cyc();
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0000_0000);

        // Two compressed instructions in one word.
        imem_ack = 1'b1; imem_rdata = 32'h0001_4501;
        #1;
        check("empty_not_valid", {31'd0, inst_valid}, 32'd0);
        cyc();
        imem_ack = 1'b0; inst_ready = 1'b1;
        #1;
        chk_inst("c0", 32'h0000_4501, 32'h0, 1'b1);
        cyc();
        chk_inst("c1", 32'h0000_0001, 32'h2, 1'b1);
        check("refetch_addr", imem_addr, 32'h4);
        cyc();
        check("drained_valid", {31'd0, inst_valid}, 32'd0);
        check("hold_req", {31'd0, imem_req}, 32'd1);
        check("hold_addr", imem_addr, 32'h4);

        // Reset mid-request with a response in the same cycle.
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        cyc();
        rst = 1'b0; imem_ack = 1'b0;
        #1;
        check("midrst_req", {31'd0, imem_req}, 32'd0);
        check("midrst_valid", {31'd0, inst_valid}, 32'd0);
        cyc();
        check("restart_req", {31'd0, imem_req}, 32'd1);
        check("restart_addr", imem_addr, 32'h0);

        // Compressed followed by a 32-bit instruction split across words.
        imem_ack = 1'b1; imem_rdata = 32'h0513_4501; inst_ready = 1'b0;
        cyc();
        imem_ack = 1'b0; inst_ready = 1'b1;
        #1;
        chk_inst("cli", 32'h0000_4501, 32'h0, 1'b1);
        cyc();
        check("split_wait_valid", {31'd0, inst_valid}, 32'd0);
        check("split_req_addr", imem_addr, 32'h4);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
        #1;
        check("split_ack_cycle_valid", {31'd0, inst_valid}, 32'd0);
        cyc();
        imem_ack = 1'b0;
        #1;
        chk_inst("w32", 32'h0000_0513, 32'h2, 1'b0);
        cyc();

        // Decoder stall for ten cycles.
        inst_ready = 1'b0;
        acks = 0;
        bad  = 0;
        for (int i = 0; i < 10; i++) begin
            imem_ack   = imem_req;
            imem_rdata = 32'h0001_0001;
            if (imem_req) acks++;
            #1;
            if (!inst_valid || inst !== 32'h0 || inst_pc !== 32'h6) bad++;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        #1;
        check("stall_acks", acks, 32'd1);
        check("stall_inst_stable", bad, 32'd0);
        check("stall_no_req", {31'd0, imem_req}, 32'd0);
        inst_ready = 1'b1;
        #1;
        chk_inst("rel0", 32'h0, 32'h6, 1'b1);
        cyc();
        chk_inst("rel1", 32'h1, 32'h8, 1'b1);
        cyc();
        inst_ready = 1'b0;
        #1;
        chk_inst("rel2", 32'h1, 32'hA, 1'b1);
        check("rel_req_addr", imem_addr, 32'hC);

        // Redirect while a request is open without ack.
        redirect = 1'b1; redirect_pc = 32'h0000_0102;
        #1;
        check("redir_valid_gate", {31'd0, inst_valid}, 32'd0);
        cyc();
        redirect = 1'b0;
        #1;
        check("discard_req", {31'd0, imem_req}, 32'd1);
        check("discard_stale_addr", imem_addr, 32'hC);
        check("discard_valid", {31'd0, inst_valid}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc();
        imem_ack = 1'b0;
        #1;
        check("discard_dropped", {31'd0, inst_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'h100);
        imem_ack = 1'b1; imem_rdata = 32'h4501_FFFF;
        cyc();
        imem_ack = 1'b0;
        #1;
        chk_inst("redir_first", 32'h0000_4501, 32'h102, 1'b1);
        cyc();
        check("next_addr", imem_addr, 32'h104);

        // Redirect and ack in the same cycle.
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        #1;
        check("redir_ack_valid", {31'd0, inst_valid}, 32'd0);
        cyc();
        redirect = 1'b0; imem_ack = 1'b0;
        #1;
        check("redir_ack_req", {31'd0, imem_req}, 32'd1);
        check("redir_ack_addr", imem_addr, 32'h200);
        check("redir_ack_dropped", {31'd0, inst_valid}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h0000_4501;
        cyc();
        imem_ack = 1'b0;
        #1;
        chk_inst("tgt200", 32'h0000_4501, 32'h200, 1'b1);

        // Wrap of fetch and head pointers.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        cyc();
        redirect = 1'b0;
        #1;
        check("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1'b1; imem_rdata = 32'h0513_ABCD;
        cyc();
        imem_ack = 1'b0;
        #1;
        check("wrap_split_wait", {31'd0, inst_valid}, 32'd0);
        cyc();
        wait_req("wrap_fetch", 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
        cyc();
        imem_ack = 1'b0; inst_ready = 1'b1;
        #1;
        chk_inst("wrap_w32", 32'h0000_0513, 32'hFFFF_FFFE, 1'b0);
        cyc();
        inst_ready = 1'b0;
        #1;
        check("wrap_head_pc", inst_pc, 32'h2);
        check("wrap_head_valid", {31'd0, inst_valid}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/ifetch_align.md
IFETCH_ALIGN -- requirements
Module: ifetch_align

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first instruction address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port imem_req, output, 1, instruction-memory word read request.
REQ-005 The block SHALL have port imem_addr, output, 32, word-aligned read address with bits [1:0] always 0.
REQ-006 The block SHALL have port imem_ack, input, 1, read complete; imem_rdata valid in the same cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32, little-endian read word, low halfword at the lower address.
REQ-008 The block SHALL have port redirect, input, 1, one-cycle flush request from branch/jump.
REQ-009 The block SHALL have port redirect_pc, input, 32, new fetch target; bit 0 ignored.
REQ-010 The block SHALL have port inst_valid, output, 1, aligned instruction available to the decoder.
REQ-011 The block SHALL have port inst_ready, input, 1, decoder accepts the instruction.
REQ-012 The block SHALL have port inst, output, 32, the instruction; for 16-bit instructions [31:16]=0.
REQ-013 The block SHALL have port inst_pc, output, 32, byte address of inst.
REQ-014 The block SHALL have port inst_is_c, output, 1, high when inst[1:0] != 2'b11.

Function
REQ-015 The block SHALL hold a 3-entry halfword queue (hq_count 0..3), queue head PC head_pc, next word address fetch_pc, and a skip_lo flag.
REQ-016 The block SHALL implement FSM states IDLE (no request), REQ (imem_req=1 at fetch_pc), and DISCARD (imem_req=1 at the stale address, response dropped).
REQ-017 The block SHALL hold imem_req and imem_addr stable from assertion until the cycle imem_ack=1.
REQ-018 IDLE->REQ SHALL occur when hq_count after this cycle's pop is <= 1 and redirect=0.
REQ-019 On ack in REQ, the block SHALL append both halfwords (low first), or only the high halfword when skip_lo=1, then clear skip_lo, advance fetch_pc by 4, and go to IDLE.
REQ-020 A pop and an append in the same cycle SHALL apply pop before append; hq_count SHALL never exceed 3.
REQ-021 inst_valid SHALL be 1 when redirect=0 and either hq_count>=2, or hq_count>=1 and head[1:0]!=2'b11.
REQ-022 inst SHALL be the head halfword zero-extended when compressed, otherwise {entry1, head}; inst_pc SHALL equal head_pc.
REQ-023 On inst_valid&inst_ready, the block SHALL pop 1 entry (compressed) or 2 entries (32-bit) and advance head_pc by 2 or 4.
REQ-024 A 32-bit instruction split across two words SHALL be output only after both halves are queued.
REQ-025 Latency SHALL be one cycle: ack in cycle N gives inst_valid in N+1 when data suffices.
REQ-026 On redirect, the block SHALL clear the queue, set head_pc={redirect_pc[31:1],0}, set fetch_pc={redirect_pc[31:2],00}, set skip_lo=redirect_pc[1], and suppress any pop.
REQ-027 Redirect in IDLE SHALL go to REQ on the next cycle.
REQ-028 Redirect in REQ with ack in the same cycle SHALL drop the data and go to REQ at the new address.
REQ-029 Redirect in REQ without ack SHALL go to DISCARD; ack in DISCARD SHALL drop the data and go to REQ.
REQ-030 Redirect in DISCARD SHALL update the target only and stay in DISCARD.
REQ-031 fetch_pc and head_pc SHALL wrap modulo 2^32 without error.

Reset
REQ-032 With rst=1 at a clock edge, the block SHALL set state=IDLE, imem_req=0, hq_count=0, inst_valid=0, head_pc=RESET_PC with bit 0 cleared, fetch_pc=RESET_PC with [1:0] cleared, and skip_lo=RESET_PC[1].
REQ-033 rst SHALL override redirect and ack in the same cycle; any in-flight response SHALL be dropped.
REQ-034 imem_req SHALL first assert in the cycle after rst deasserts.

Verification
REQ-035 The bench SHALL cover: reset with RESET_PC=0; word 0x0001_4501 acked -> inst=0x0000_4501 at pc 0, then inst=0x0000_0001 at pc 2, inst_is_c=1 both.
REQ-036 The bench SHALL cover: words 0x0513_4501, 0x0000_0000 -> c.li at pc 0, then 32-bit inst=0x0000_0513 at pc 2, valid only after the second ack.
REQ-037 The bench SHALL cover: inst_ready=0 for 10 cycles -> hq_count<=3, no request issued while >1, inst stable.
REQ-038 The bench SHALL cover: redirect_pc=0x0000_0102 while in REQ without ack -> DISCARD, stale data dropped, next imem_addr=0x100, first inst_pc=0x102.
REQ-039 The bench SHALL cover: redirect and imem_ack in the same cycle -> data dropped, imem_addr=new target next cycle, inst_valid=0 in the redirect cycle.
REQ-040 The bench SHALL cover: rst asserted mid-REQ -> imem_req=0 next cycle, then restart at RESET_PC.
